// File: rtl/exec_trace_buffer_pkg.sv
// Shared definitions for the execution trace buffer: state encoding and the
// width of one stored trace entry {addr, we, reg, data}.
package exec_trace_buffer_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DUMP  = 2'd3
  } trace_state_e;

  function automatic int unsigned entry_width(input int unsigned addr_w,
                                              input int unsigned data_w);
    return addr_w + 1 + REG_W + data_w;
  endfunction

endpackage

// File: rtl/exec_trace_buffer_trace_ram.sv
// Simple dual-port trace storage: one write port, one synchronous read port.
// Contents are deliberately not reset; the fill count guards against stale reads.
module trace_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 50
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/exec_trace_buffer.sv
// Execution trace buffer: records retired instructions into a circular buffer
// around a trigger address, then replays the window oldest-first on a valid/ready port.
module exec_trace_buffer
  import exec_trace_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic              commit_valid,
  input  logic [ADDR_W-1:0] commit_addr,
  input  logic              commit_we,
  input  logic [REG_W-1:0]  commit_reg,
  input  logic [DATA_W-1:0] commit_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_we,
  output logic [REG_W-1:0]  out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        state
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned FILL_W    = PTR_W + 1;
  localparam int unsigned ENTRY_W   = entry_width(ADDR_W, DATA_W);
  localparam int unsigned POST_LAST = (POST_TRIG > 0) ? POST_TRIG - 1 : 0;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "exec_trace_buffer: DEPTH must be a power of two >= 4");
  end
  if (POST_TRIG >= DEPTH) begin : g_bad_post
    $fatal(1, "exec_trace_buffer: POST_TRIG must be less than DEPTH");
  end

  trace_state_e      state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0]  post_cnt_q, post_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              last_pend_q, last_pend_d;
  logic              valid_d, last_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [REG_W-1:0]  reg_d;
  logic [DATA_W-1:0] data_d;
  logic              slot_free;
  logic              ram_we, ram_re;
  logic [PTR_W-1:0]  ram_raddr;
  logic [ENTRY_W-1:0] ram_wdata, ram_rdata;

  assign state     = state_q;
  assign ram_wdata = {commit_addr, commit_we, commit_reg, commit_data};
  // During DUMP wr_ptr is frozen, so draining fill walks the read pointer forward.
  assign ram_raddr = wr_ptr_q - fill_q[PTR_W-1:0];

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_trace_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Next-state, capture and dump pipeline control.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    post_cnt_d  = post_cnt_q;
    rd_pend_d   = rd_pend_q;
    last_pend_d = last_pend_q;
    valid_d     = out_valid;
    last_d      = out_last;
    addr_d      = out_addr;
    we_d        = out_we;
    reg_d       = out_reg;
    data_d      = out_data;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    slot_free   = !out_valid || out_ready;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_ARMED;
          wr_ptr_d = '0;
          fill_d   = '0;
        end
      end
      ST_ARMED, ST_POST: begin
        if (commit_valid) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + FILL_W'(1);
          if (state_q == ST_ARMED) begin
            if (commit_addr == trig_addr) begin
              state_d    = (POST_TRIG == 0) ? ST_DUMP : ST_POST;
              post_cnt_d = '0;
            end
          end else begin
            post_cnt_d = post_cnt_q + PTR_W'(1);
            if (post_cnt_q == PTR_W'(POST_LAST)) state_d = ST_DUMP;
          end
        end
      end
      ST_DUMP: begin
        // Two-stage pipe: RAM read data waits in rd_pend until the output slot frees.
        if (slot_free) begin
          valid_d = rd_pend_q;
          last_d  = rd_pend_q && last_pend_q;
          if (rd_pend_q) begin
            addr_d = ram_rdata[ENTRY_W-1 -: ADDR_W];
            we_d   = ram_rdata[DATA_W+REG_W];
            reg_d  = ram_rdata[DATA_W +: REG_W];
            data_d = ram_rdata[DATA_W-1:0];
          end
        end
        if ((fill_q != '0) && (!rd_pend_q || slot_free)) begin
          ram_re      = 1'b1;
          fill_d      = fill_q - FILL_W'(1);
          rd_pend_d   = 1'b1;
          last_pend_d = (fill_q == FILL_W'(1));
        end else if (rd_pend_q && slot_free) begin
          rd_pend_d = 1'b0;
        end
        if (out_valid && out_ready && out_last) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      rd_pend_d = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_addr    <= '0;
      out_we      <= 1'b0;
      out_reg     <= '0;
      out_data    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_cnt_q  <= post_cnt_d;
      rd_pend_q   <= rd_pend_d;
      last_pend_q <= last_pend_d;
      out_valid   <= valid_d;
      out_last    <= last_d;
      out_addr    <= addr_d;
      out_we      <= we_d;
      out_reg     <= reg_d;
      out_data    <= data_d;
    end
  end

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed bench for exec_trace_buffer: a DEPTH=8/POST_TRIG=2 instance and a
// POST_TRIG=0 instance sharing stimulus; one of them is monitored at a time.
module tb_exec_trace_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0, abort = 1'b0, commit_valid = 1'b0, commit_we = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] trig_addr = '0, commit_addr = '0;
  logic [4:0]  commit_reg = '0;
  logic [31:0] commit_data = '0;

  logic        a_valid, a_we, a_last, b_valid, b_we, b_last;
  logic [11:0] a_addr, b_addr;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic [1:0]  a_state, b_state;

  logic        sel_b = 1'b0;
  logic        mon_valid, mon_we, mon_last;
  logic [11:0] mon_addr;
  logic [4:0]  mon_reg;
  logic [31:0] mon_data;
  logic [1:0]  mon_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  exec_trace_buffer #(.ADDR_W(12), .DATA_W(32), .DEPTH(8), .POST_TRIG(2)) u_dut_a (
    .clock(clock), .reset(reset), .arm(arm), .abort(abort), .trig_addr(trig_addr),
    .commit_valid(commit_valid), .commit_addr(commit_addr), .commit_we(commit_we),
    .commit_reg(commit_reg), .commit_data(commit_data), .out_valid(a_valid),
    .out_ready(out_ready), .out_addr(a_addr), .out_we(a_we), .out_reg(a_reg),
    .out_data(a_data), .out_last(a_last), .state(a_state));

  exec_trace_buffer #(.ADDR_W(12), .DATA_W(32), .DEPTH(8), .POST_TRIG(0)) u_dut_b (
    .clock(clock), .reset(reset), .arm(arm), .abort(abort), .trig_addr(trig_addr),
    .commit_valid(commit_valid), .commit_addr(commit_addr), .commit_we(commit_we),
    .commit_reg(commit_reg), .commit_data(commit_data), .out_valid(b_valid),
    .out_ready(out_ready), .out_addr(b_addr), .out_we(b_we), .out_reg(b_reg),
    .out_data(b_data), .out_last(b_last), .state(b_state));

  assign mon_valid = sel_b ? b_valid : a_valid;
  assign mon_we    = sel_b ? b_we    : a_we;
  assign mon_last  = sel_b ? b_last  : a_last;
  assign mon_addr  = sel_b ? b_addr  : a_addr;
  assign mon_reg   = sel_b ? b_reg   : a_reg;
  assign mon_data  = sel_b ? b_data  : a_data;
  assign mon_state = sel_b ? b_state : a_state;

  typedef struct {
    logic        arm;
    logic        cv;
    logic [11:0] caddr;
    logic        ready;
    logic [1:0]  st;
    logic        ov;
    logic [11:0] oaddr;
    logic        olast;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic a, input logic cv, input int ca, input logic rdy,
                              input logic [1:0] st, input logic ov, input int oa,
                              input logic ol);
    vec_t v;
    v.arm = a; v.cv = cv; v.caddr = 12'(ca); v.ready = rdy;
    v.st = st; v.ov = ov; v.oaddr = 12'(oa); v.olast = ol;
    return v;
  endfunction

  function automatic logic [31:0] exp_data(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_commit(input logic cv, input int addr);
    commit_valid = cv;
    commit_addr  = 12'(addr);
    commit_we    = 1'(addr & 1);
    commit_reg   = 5'(addr);
    commit_data  = exp_data(addr);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input int addr);
    set_commit(1'b1, addr);
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Consume n consecutive-address entries; stall=1 drives ready 1,0,1,0...
  task automatic drain(input string name, input int first, input int n, input bit stall);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 80) begin
      out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
      if (mon_valid) begin
        check({name, "_addr"}, 32'(mon_addr), 32'(first + idx));
        check({name, "_data"}, mon_data, exp_data(first + idx));
        check({name, "_we"},   32'(mon_we),   32'((first + idx) & 1));
        check({name, "_reg"},  32'(mon_reg),  32'((first + idx) & 31));
        check({name, "_last"}, 32'(mon_last), 32'(idx == n - 1));
        if (out_ready) idx++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (idx < n) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d entries expected %0d", name, idx, n);
    end
    check({name, "_end_state"}, 32'(mon_state), 32'd0);
    check({name, "_end_valid"}, 32'(mon_valid), 32'd0);
  endtask

  task automatic capture_15_22();
    pulse_abort();
    trig_addr = 12'd20;
    pulse_arm();
    for (int i = 0; i <= 22; i++) commit(i);
    check("win_dump_entry", 32'(mon_state), 32'd3);
  endtask

  task automatic wait_valid(input string name);
    int cyc = 0;
    while (!mon_valid && cyc < 6) begin
      tick();
      cyc++;
    end
    check({name, "_valid_rise"}, 32'(mon_valid), 32'd1);
  endtask

  initial begin
    // Asynchronous reset between clock edges
    #2 reset = 1'b0;
    #1;
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_last",  32'(a_last),  32'd0);
    check("rst_addr",  32'(a_addr),  32'd0);
    check("rst_data",  a_data,       32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Short window, trigger at addr 1, includes ignored commit in IDLE and ignored arm
    trig_addr = 12'd1;
    vecs[0]  = mk(1'b0, 1'b1, 1, 1'b0, 2'd0, 1'b0, 0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 0, 1'b0, 2'd1, 1'b0, 0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 0, 1'b0, 2'd1, 1'b0, 0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 1, 1'b0, 2'd2, 1'b0, 0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 2, 1'b0, 2'd2, 1'b0, 0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 3, 1'b0, 2'd3, 1'b0, 0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 0, 1'b1, 2'd3, 1'b0, 0, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 0, 1'b1, 2'd3, 1'b1, 0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 0, 1'b1, 2'd3, 1'b1, 1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 0, 1'b1, 2'd3, 1'b1, 2, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 0, 1'b1, 2'd3, 1'b1, 3, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 0, 1'b1, 2'd0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      arm = vecs[i].arm;
      set_commit(vecs[i].cv, int'(vecs[i].caddr));
      out_ready = vecs[i].ready;
      tick();
      check($sformatf("tbl%0d_state", i), 32'(a_state), 32'(vecs[i].st));
      check($sformatf("tbl%0d_valid", i), 32'(a_valid), 32'(vecs[i].ov));
      check($sformatf("tbl%0d_last", i),  32'(a_last),  32'(vecs[i].olast));
      if (vecs[i].ov) begin
        check($sformatf("tbl%0d_addr", i), 32'(a_addr), 32'(vecs[i].oaddr));
        check($sformatf("tbl%0d_data", i), a_data, exp_data(int'(vecs[i].oaddr)));
      end
    end
    arm = 1'b0;
    commit_valid = 1'b0;
    out_ready = 1'b0;

    // Wrapped window, free-running consumer then alternating stalls
    capture_15_22();
    drain("wrap", 15, 8, 1'b0);
    capture_15_22();
    drain("stall", 15, 8, 1'b1);

    // Abort during DUMP drops out_valid on the next edge
    capture_15_22();
    wait_valid("abort_dump");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_dump_valid", 32'(a_valid), 32'd0);
    check("abort_dump_state", 32'(a_state), 32'd0);

    // Abort in POST after one post-trigger commit
    trig_addr = 12'd5;
    pulse_arm();
    commit(4);
    commit(5);
    check("post_entry", 32'(a_state), 32'd2);
    commit(6);
    check("post_one", 32'(a_state), 32'd2);
    abort = 1'b1;
    set_commit(1'b1, 7);
    tick();
    abort = 1'b0;
    commit_valid = 1'b0;
    check("abort_post_state", 32'(a_state), 32'd0);
    begin
      int seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (i < 3) commit(8 + i); else tick();
        if (a_valid) seen++;
      end
      out_ready = 1'b0;
      check("abort_post_never_valid", 32'(seen), 32'd0);
      check("abort_post_idle", 32'(a_state), 32'd0);
    end

    // Reset mid-dump discards the trace; only a fresh arm restarts capture
    capture_15_22();
    wait_valid("rst_dump");
    #2 reset = 1'b0;
    #1;
    check("rst_mid_state", 32'(a_state), 32'd0);
    check("rst_mid_valid", 32'(a_valid), 32'd0);
    check("rst_mid_addr",  32'(a_addr),  32'd0);
    check("rst_mid_data",  a_data,       32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    trig_addr = 12'd1;
    commit(0);
    commit(1);
    check("rst_no_arm", 32'(a_state), 32'd0);
    pulse_arm();
    for (int i = 0; i < 4; i++) commit(i);
    drain("rearm", 0, 4, 1'b0);

    // POST_TRIG=0 instance: immediate DUMP, later commit not captured
    sel_b = 1'b1;
    pulse_abort();
    trig_addr = 12'd5;
    pulse_arm();
    commit(3);
    commit(4);
    check("pt0_pre", 32'(b_state), 32'd1);
    commit(5);
    check("pt0_dump", 32'(b_state), 32'd3);
    commit(6);
    drain("pt0", 3, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
